plane_agent: RTL and testbench
==============================

Name: plane_agent

Overview:
- Aircraft-side initiator for the tower controller's 9-bit message protocol. It sends one takeoff or landing request for a fixed plane ID and parses the tower's replies (hold, clear, say-again, divert).
- It occupies the granted runway for a fixed time, then sends the runway-clear declaration.
- Used as a bus-functional traffic source in system benches. Several instances share the tower input through an external arbiter.
- Message format, both directions: [8:5] plane ID, [4:2] type, [1:0] action.
  - Types: 000 request (action[1]: 0 = takeoff, 1 = landing); 001 runway clear (action[0] = runway); 011 cleared (action = {0, runway}); 100 hold; 101 say again; 110 divert.

Parameters:
- PLANE_ID, 4'd1, 4-bit ID placed in [8:5] of every sent message; only replies with this ID are accepted.
- TIMEOUT, 64, cycles to wait in WAIT for an accepted reply before re-sending.
- MAX_RETRIES, 3, re-send limit before giving up (minimum 1).
- RUNWAY_CYCLES, 16, cycles spent on the runway after clearance (minimum 1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  start a new operation
- cmd_landing  in  1  0 = takeoff, 1 = landing; sampled when cmd_valid && cmd_ready
- cmd_ready  out  1  high only in IDLE
- tx_data  out  9  message to tower
- tx_valid  out  1  one-cycle write strobe for tx_data
- tx_busy  in  1  tower input FIFO full; no write while high
- rx_data  in  9  reply from tower
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- on_runway  out  1  high while in RUNWAY
- runway_id  out  1  runway granted by the last accepted clear
- done  out  1  one-cycle pulse when an operation ends
- result  out  2  valid with done: 00 completed, 01 diverted, 10 timed out
- retries  out  2  re-sends used in the current operation

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except cmd_ready = 1; counters cleared. A reset in any state aborts with no further messages and no done pulse.
- All outputs are registered. tx_valid is high for exactly one cycle per message, with tx_data stable in that cycle.
- A reply is "accepted" only when rx_valid && rx_data[8:5] == PLANE_ID. All other replies are ignored.

States:
- IDLE: cmd_ready = 1. On cmd_valid, latch cmd_landing, clear retries → REQ.
- REQ: if !tx_busy, pulse tx_valid with {PLANE_ID, 000, {landing, 0}}, load the timeout counter → WAIT. Otherwise hold in REQ with tx_valid = 0. The timeout counter does not run in REQ.
- WAIT: the timeout counter decrements each cycle. Accepted replies:
  - 011 with action[1] = 0: latch runway_id = action[0], load RUNWAY_CYCLES → RUNWAY.
  - 100: → HOLD.
  - 110: → DONE with result 01.
  - 101: treated as a retry.
  - 011 with action[1] = 1, or any other type: ignored.
- Timeout expiry (counter reaches 0 with no accepted reply) is also a retry.
- Retry: if retries == MAX_RETRIES → DONE with result 10; otherwise retries++ → REQ.
- A reply accepted in the same cycle as timeout expiry takes priority over the timeout.
- HOLD: no timeout. Accepted 011 → RUNWAY, same as in WAIT. 110 → DONE/01. 101 → retry. 100 → stay.
- RUNWAY: on_runway = 1; decrement the counter; at 0 → REL. All replies are ignored.
- REL: wait for !tx_busy, pulse tx_valid with {PLANE_ID, 001, {landing, runway_id}} → DONE with result 00.
- DONE: pulse done for one cycle with result → IDLE. cmd_ready returns high the following cycle.
- Counter widths: $clog2 of the parameter + 1; no wrap is possible.

Test Plan:
- Takeoff, PLANE_ID = 3: cmd_landing = 0 → tx_data 9'b0011_000_00. Reply 9'b0011_011_01 → on_runway = 1, runway_id = 1 for 16 cycles. Then tx_data 9'b0011_001_01, done = 1, result = 00.
- Landing with hold: reply 0011_100_00, then 30 idle cycles, then 0011_011_00 → no resend during hold; release sends 0011_001_10.
- Foreign ID and busy: reply 0101_011_00 is ignored. tx_busy is held high for 10 cycles at REL → tx_valid stays 0 until tx_busy falls.
- Timeout, TIMEOUT = 8, MAX_RETRIES = 3, no replies → 4 requests total, spaced ≥8 cycles apart; done with result 10, retries = 3.
- Divert and say-again: reply 101 → immediate re-send with retries = 1; then reply 110 → done, result 01.
- Reset asserted in RUNWAY → next cycle IDLE, on_runway = 0, no clear message, no done pulse.

Source files
------------

// File: rtl/plane_agent.sv
// Aircraft-side initiator for the tower's 9-bit message protocol: one request
// per operation, reply parsing with retries, timed runway occupancy, release.
module plane_agent #(
  parameter logic [3:0]  PLANE_ID      = 4'd1,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned RUNWAY_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_landing,
  output logic       cmd_ready,
  output logic [8:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  input  logic [8:0] rx_data,
  input  logic       rx_valid,
  output logic       on_runway,
  output logic       runway_id,
  output logic       done,
  output logic [1:0] result,
  output logic [1:0] retries
);

  localparam int unsigned TW  = $clog2(TIMEOUT) + 1;
  localparam int unsigned RCW = $clog2(RUNWAY_CYCLES) + 1;
  localparam int unsigned CW  = (TW > RCW) ? TW : RCW;
  localparam int unsigned NW  = $clog2(MAX_RETRIES) + 1;

  localparam logic [2:0] T_REQ  = 3'b000;
  localparam logic [2:0] T_REL  = 3'b001;
  localparam logic [2:0] T_CLR  = 3'b011;
  localparam logic [2:0] T_HOLD = 3'b100;
  localparam logic [2:0] T_SAY  = 3'b101;
  localparam logic [2:0] T_DIV  = 3'b110;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_DIV = 2'b01;
  localparam logic [1:0] R_TMO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_RUNWAY, ST_REL, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   retries_q, retries_d;
  logic            landing_q, landing_d;
  logic            runway_q, runway_d;
  logic [1:0]      result_q, result_d;
  logic [8:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            on_runway_q, on_runway_d;
  logic            done_q, done_d;
  logic            acc, rx_clr, rx_hold, rx_say, rx_div, do_retry;

  // Decode replies addressed to this plane.
  always_comb begin
    acc     = rx_valid && (rx_data[8:5] == PLANE_ID);
    rx_clr  = acc && (rx_data[4:2] == T_CLR) && !rx_data[1];
    rx_hold = acc && (rx_data[4:2] == T_HOLD);
    rx_say  = acc && (rx_data[4:2] == T_SAY);
    rx_div  = acc && (rx_data[4:2] == T_DIV);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retries_d  = retries_q;
    landing_d  = landing_q;
    runway_d   = runway_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    do_retry   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          landing_d = cmd_landing;
          retries_d = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {PLANE_ID, T_REQ, landing_q, 1'b0};
          cnt_d      = CW'(TIMEOUT);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (rx_clr) begin
          runway_d = rx_data[0];
          cnt_d    = CW'(RUNWAY_CYCLES);
          state_d  = ST_RUNWAY;
        end else if (rx_hold) begin
          state_d = ST_HOLD;
        end else if (rx_div) begin
          result_d = R_DIV;
          state_d  = ST_DONE;
        end else if (rx_say || (cnt_q <= CW'(1))) begin
          do_retry = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rx_clr) begin
          runway_d = rx_data[0];
          cnt_d    = CW'(RUNWAY_CYCLES);
          state_d  = ST_RUNWAY;
        end else if (rx_div) begin
          result_d = R_DIV;
          state_d  = ST_DONE;
        end else if (rx_say) begin
          do_retry = 1'b1;
        end
      end
      ST_RUNWAY: begin
        if (cnt_q <= CW'(1)) state_d = ST_REL;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      ST_REL: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {PLANE_ID, T_REL, landing_q, runway_q};
          result_d   = R_OK;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Say-again and timeout share the retry budget.
    if (do_retry) begin
      if (retries_q == NW'(MAX_RETRIES)) begin
        result_d = R_TMO;
        state_d  = ST_DONE;
      end else begin
        retries_d = retries_q + NW'(1);
        state_d   = ST_REQ;
      end
    end

    cmd_ready_d = (state_d == ST_IDLE);
    on_runway_d = (state_d == ST_RUNWAY);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retries_q   <= '0;
      landing_q   <= 1'b0;
      runway_q    <= 1'b0;
      result_q    <= 2'b00;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      on_runway_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      landing_q   <= landing_d;
      runway_q    <= runway_d;
      result_q    <= result_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cmd_ready_q <= cmd_ready_d;
      on_runway_q <= on_runway_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign on_runway = on_runway_q;
  assign runway_id = runway_q;
  assign done      = done_q;
  assign result    = result_q;
  assign retries   = 2'(retries_q);

endmodule

// File: tb/tb_plane_agent.sv
// Scoreboard bench for plane_agent: a protocol-level model predicts the
// message/done sequence per operation; a monitor checks what the DUT emits.
module tb_plane_agent;

  localparam logic [3:0] ID   = 4'd3;
  localparam int         TMO  = 8;
  localparam int         MAXR = 3;
  localparam int         RWC  = 16;

  localparam int C_CLEAR = 0, C_HOLD_CLEAR = 1, C_SAY = 2, C_DIV = 3,
                 C_NONE = 4, C_HOLD_SAY = 5, C_HOLD_DIV = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_landing = 1'b0;
  logic       cmd_ready;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic [8:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       on_runway, runway_id, done;
  logic [1:0] result, retries;

  logic force_busy = 1'b0, rand_busy = 1'b0, rand_busy_en = 1'b0;
  assign tx_busy = force_busy | rand_busy;

  plane_agent #(.PLANE_ID(ID), .TIMEOUT(TMO), .MAX_RETRIES(MAXR), .RUNWAY_CYCLES(RWC)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_landing(cmd_landing),
    .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .on_runway(on_runway), .runway_id(runway_id),
    .done(done), .result(result), .retries(retries)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) rand_busy <= rand_busy_en && ($urandom_range(0, 2) == 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", nm, act, lim);
    end
  endtask

  typedef struct {
    bit         is_done;
    logic [8:0] data;
    logic [1:0] res;
    logic [1:0] ret;
  } exp_t;
  exp_t expq[$];

  task automatic push_tx(input logic [8:0] m);
    exp_t e;
    e.is_done = 1'b0; e.data = m; e.res = 2'b00; e.ret = 2'b00;
    expq.push_back(e);
  endtask

  task automatic push_done(input logic [1:0] r, input int n);
    exp_t e;
    e.is_done = 1'b1; e.data = '0; e.res = r; e.ret = 2'(n);
    expq.push_back(e);
  endtask

  // Monitor: every message and done pulse must match the next expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (tx_valid) begin
        if (expq.size() == 0 || expq[0].is_done) begin
          chk("unexpected_tx", int'(tx_data), -1);
        end else begin
          chk("tx_data", int'(tx_data), int'(expq[0].data));
          void'(expq.pop_front());
        end
      end
      if (done) begin
        if (expq.size() == 0 || !expq[0].is_done) begin
          chk("unexpected_done", int'(result), -1);
        end else begin
          chk("done_result", int'(result), int'(expq[0].res));
          chk("done_retries", int'(retries), int'(expq[0].ret));
          void'(expq.pop_front());
        end
      end
    end
  end

  int plan_codes[4];
  bit plan_rw[4];

  function automatic int final_of(input int c);
    case (c)
      C_HOLD_CLEAR: return C_CLEAR;
      C_HOLD_SAY:   return C_SAY;
      C_HOLD_DIV:   return C_DIV;
      default:      return c;
    endcase
  endfunction

  function automatic bit is_hold(input int c);
    return (c == C_HOLD_CLEAR) || (c == C_HOLD_SAY) || (c == C_HOLD_DIV);
  endfunction

  // Reference model: protocol outcome of a planned reply sequence.
  task automatic model_op(input bit landing, input int n, input bit abort);
    int r;
    int f;
    r = 0;
    for (int i = 0; i < n; i++) begin
      push_tx({ID, 3'b000, landing, 1'b0});
      f = final_of(plan_codes[i]);
      if (f == C_CLEAR) begin
        if (!abort) begin
          push_tx({ID, 3'b001, landing, plan_rw[i]});
          push_done(2'b00, r);
        end
        break;
      end else if (f == C_DIV) begin
        push_done(2'b01, r);
        break;
      end else if (r == MAXR) begin
        push_done(2'b10, r);
        break;
      end else begin
        r++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_reply(input logic [8:0] m);
    rx_data  = m;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  function automatic logic [8:0] ignored_msg(input bit own_ok);
    logic [3:0] fid;
    int k;
    fid = 4'($urandom_range(0, 15));
    if (fid == ID) fid = ID + 4'd1;
    k = own_ok ? $urandom_range(0, 3) : 0;
    case (k)
      1:       return {ID, 3'b011, 1'b1, 1'($urandom_range(0, 1))};
      2:       return {ID, 3'b001, 2'($urandom_range(0, 3))};
      3:       return {ID, 3'b111, 2'($urandom_range(0, 3))};
      default: return {fid, 3'b011, 2'($urandom_range(0, 3))};
    endcase
  endfunction

  task automatic run_op(input bit landing, input int n, input bit rnd, input bit foreign,
                        input bit busy_rel, input int hold_cyc, input bit rst_rw);
    int  t_prev;
    int  k;
    int  cnt;
    int  c;
    int  f;
    int  bad;
    bit  got;
    t_prev = 0;
    model_op(landing, n, rst_rw);

    k = 0;
    while (!cmd_ready && k < 300) begin @(negedge clock); k++; end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid   = 1'b1;
    cmd_landing = landing;
    @(negedge clock);
    cmd_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int w = 0; w < 300; w++) begin
        if (tx_valid && w > 0) begin got = 1'b1; break; end
        @(negedge clock);
      end
      chk("request_seen", int'(got), 1);
      if (!got) return;
      chk("retries_at_req", int'(retries), i);
      if (i > 0 && plan_codes[i-1] == C_NONE) chk_ge("timeout_spacing", cyc - t_prev, TMO);
      t_prev = cyc;

      c = plan_codes[i];
      f = final_of(c);
      if (rnd) idle($urandom_range(0, 2));
      if (rnd && ($urandom_range(0, 1) == 1)) send_reply(ignored_msg(1'b1));
      if (foreign) send_reply({4'b0101, 3'b011, 2'b00});
      if (is_hold(c)) begin
        send_reply({ID, 3'b100, 2'b00});
        idle(hold_cyc);
        if (rnd && ($urandom_range(0, 1) == 1)) send_reply({ID, 3'b100, 2'b00});
        if (rnd && ($urandom_range(0, 1) == 1)) send_reply(ignored_msg(1'b0));
      end
      case (f)
        C_CLEAR: begin
          if (busy_rel) force_busy = 1'b1;
          send_reply({ID, 3'b011, 1'b0, plan_rw[i]});
          k = 0;
          while (!on_runway && k < 8) begin @(negedge clock); k++; end
          chk("on_runway_rise", int'(on_runway), 1);
          if (!on_runway) begin force_busy = 1'b0; return; end
          chk("runway_id", int'(runway_id), int'(plan_rw[i]));
          cnt = 0;
          while (on_runway && cnt < 60) begin
            cnt++;
            if (rst_rw && cnt == 4) begin
              reset = 1'b1;
              @(negedge clock);
              chk("rst_cmd_ready", int'(cmd_ready), 1);
              chk("rst_on_runway", int'(on_runway), 0);
              chk("rst_tx_valid", int'(tx_valid), 0);
              chk("rst_done", int'(done), 0);
              reset = 1'b0;
              idle(40);
              return;
            end
            if (rnd && cnt == 3) send_reply({ID, 3'b110, 2'b00});
            else @(negedge clock);
          end
          chk("runway_cycles", cnt, RWC);
          if (busy_rel) begin
            bad = 0;
            for (int j = 0; j < 10; j++) begin
              if (tx_valid) bad++;
              @(negedge clock);
            end
            chk("tx_while_busy", bad, 0);
            force_busy = 1'b0;
          end
        end
        C_DIV: send_reply({ID, 3'b110, 2'b00});
        C_SAY: send_reply({ID, 3'b101, 2'b00});
        default: ;
      endcase
    end

    k = 0;
    while (!done && k < 300) begin @(negedge clock); k++; end
    chk("done_seen", int'(done), 1);
  endtask

  initial begin
    int n;
    int c;
    repeat (3) @(negedge clock);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_tx_valid", int'(tx_valid), 0);
    chk("reset_on_runway", int'(on_runway), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_retries", int'(retries), 0);
    chk("reset_runway_id", int'(runway_id), 0);
    reset = 1'b0;
    idle(2);

    // Takeoff, cleared onto runway 1.
    plan_codes[0] = C_CLEAR; plan_rw[0] = 1'b1;
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Landing, foreign reply, long hold, then runway 0 with a busy tower at release.
    plan_codes[0] = C_HOLD_CLEAR; plan_rw[0] = 1'b0;
    run_op(1'b1, 1, 1'b0, 1'b1, 1'b1, 30, 1'b0);
    // No replies at all: four requests, then give up.
    for (int i = 0; i < 4; i++) begin plan_codes[i] = C_NONE; plan_rw[i] = 1'b0; end
    run_op(1'b0, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Say-again, then divert.
    plan_codes[0] = C_SAY; plan_codes[1] = C_DIV;
    run_op(1'b1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Randomized operations with a randomly busy tower.
    rand_busy_en = 1'b1;
    for (int op = 0; op < 30; op++) begin
      n = 0;
      for (int i = 0; i < 4; i++) begin
        c = $urandom_range(0, 6);
        plan_codes[i] = c;
        plan_rw[i]    = 1'($urandom_range(0, 1));
        n = i + 1;
        if (final_of(c) == C_CLEAR || final_of(c) == C_DIV) break;
      end
      run_op(1'($urandom_range(0, 1)), n, 1'b1, 1'b0, 1'b0, $urandom_range(0, 20), 1'b0);
    end
    rand_busy_en = 1'b0;

    // Reset while occupying the runway: no release message, no done.
    plan_codes[0] = C_CLEAR; plan_rw[0] = 1'b1;
    run_op(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    idle(20);
    chk("scoreboard_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
